rv32m_muldiv_sequencer: RTL and testbench

RV32M_MULDIV_SEQUENCER -- requirements
Module: rv32m_muldiv_sequencer

---
 rtl/rv32m_muldiv_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_rv32m_muldiv_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_muldiv_sequencer.sv
// Sequences RV32M multiply/divide ops onto external unsigned mul/div units:
// operand magnitudes, sign fix-up, divide special cases and a one-entry result cache.
module rv32m_muldiv_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        mul,
  input  logic        div,
  input  logic        rem,
  input  logic        usign_usign,
  input  logic        sign_sign,
  input  logic        sign_usign,
  input  logic        lower_word,
  input  logic        kill,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, SIGNFIX, DONE, DRAIN} state_t;
  state_t state_reg, state_next;

  // Operand decode: index 0 is rs1, index 1 is rs2.
  logic [31:0] op_data [2];
  logic [31:0] op_mag  [2];
  logic [1:0]  op_signed;
  logic [1:0]  op_neg;

  assign op_data[0]   = rs1_data;
  assign op_data[1]   = rs2_data;
  assign op_signed[0] = ~usign_usign & (sign_sign | sign_usign);
  assign op_signed[1] = ~usign_usign & sign_sign;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign op_neg[gi] = op_signed[gi] & op_data[gi][31];
      assign op_mag[gi] = op_neg[gi] ? (~op_data[gi] + 32'd1) : op_data[gi];
    end
  endgenerate

  logic        neg_xor_reg, neg_rs1_reg, is_div_reg, sel_lo_reg;
  logic [1:0]  key_sgn_reg;
  logic [31:0] key_rs1_reg, key_rs2_reg;
  logic [63:0] raw_reg;
  logic [31:0] result_reg;
  logic [31:0] mul_a_reg, mul_b_reg, div_a_reg, div_b_reg;
  logic        mul_start_reg, div_start_reg;
  logic        cache_valid_reg, cache_div_reg;
  logic [1:0]  cache_sgn_reg;
  logic [31:0] cache_rs1_reg, cache_rs2_reg;
  logic [63:0] cache_val_reg;

  logic        accept, div_by_zero, div_ovf, bypass, cache_hit, sel_lo;
  logic [31:0] bypass_value, hit_value;

  assign accept      = (state_reg == IDLE) && start && !kill && (mul ^ div);
  assign div_by_zero = div && (rs2_data == 32'd0);
  assign div_ovf     = div && sign_sign && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign bypass      = div_by_zero || div_ovf;
  assign cache_hit   = cache_valid_reg && (cache_div_reg == div) && (cache_sgn_reg == op_signed)
                    && (cache_rs1_reg == rs1_data) && (cache_rs2_reg == rs2_data);
  // Low half holds the low product word for mul and the remainder for div.
  assign sel_lo       = div ? rem : lower_word;
  assign bypass_value = div_by_zero ? (rem ? rs1_data : 32'hFFFF_FFFF)
                                    : (rem ? 32'd0 : 32'h8000_0000);
  assign hit_value    = sel_lo ? cache_val_reg[31:0] : cache_val_reg[63:32];

  logic [31:0] fix_q, fix_r, fix_result;
  logic [63:0] fix_value;

  assign fix_q      = neg_xor_reg ? (~raw_reg[63:32] + 32'd1) : raw_reg[63:32];
  assign fix_r      = neg_rs1_reg ? (~raw_reg[31:0] + 32'd1) : raw_reg[31:0];
  assign fix_value  = is_div_reg ? {fix_q, fix_r}
                                 : (neg_xor_reg ? (~raw_reg + 64'd1) : raw_reg);
  assign fix_result = sel_lo_reg ? fix_value[31:0] : fix_value[63:32];

  always_ff @(posedge CLK) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bypass || cache_hit) state_next = DONE;
          else if (div)            state_next = DIV_WAIT;
          else                     state_next = MUL_WAIT;
        end
      end
      // A kill coinciding with the completion pulse has nothing left to drain.
      MUL_WAIT: begin
        if (kill)          state_next = mul_done ? IDLE : DRAIN;
        else if (mul_done) state_next = SIGNFIX;
      end
      DIV_WAIT: begin
        if (kill)          state_next = div_done ? IDLE : DRAIN;
        else if (div_done) state_next = SIGNFIX;
      end
      SIGNFIX: state_next = kill ? IDLE : DONE;
      DONE:    state_next = IDLE;
      DRAIN: begin
        if (is_div_reg ? div_done : mul_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      neg_xor_reg     <= 1'b0;
      neg_rs1_reg     <= 1'b0;
      is_div_reg      <= 1'b0;
      sel_lo_reg      <= 1'b0;
      key_sgn_reg     <= 2'b00;
      key_rs1_reg     <= 32'd0;
      key_rs2_reg     <= 32'd0;
      raw_reg         <= 64'd0;
      result_reg      <= 32'd0;
      mul_a_reg       <= 32'd0;
      mul_b_reg       <= 32'd0;
      div_a_reg       <= 32'd0;
      div_b_reg       <= 32'd0;
      mul_start_reg   <= 1'b0;
      div_start_reg   <= 1'b0;
      cache_valid_reg <= 1'b0;
      cache_div_reg   <= 1'b0;
      cache_sgn_reg   <= 2'b00;
      cache_rs1_reg   <= 32'd0;
      cache_rs2_reg   <= 32'd0;
      cache_val_reg   <= 64'd0;
    end else begin
      mul_start_reg <= 1'b0;
      div_start_reg <= 1'b0;
      if (accept) begin
        neg_xor_reg <= op_neg[0] ^ op_neg[1];
        neg_rs1_reg <= op_neg[0];
        is_div_reg  <= div;
        sel_lo_reg  <= sel_lo;
        key_sgn_reg <= op_signed;
        key_rs1_reg <= rs1_data;
        key_rs2_reg <= rs2_data;
        if (bypass) begin
          result_reg <= bypass_value;
        end else if (cache_hit) begin
          result_reg <= hit_value;
        end else if (div) begin
          div_start_reg <= 1'b1;
          div_a_reg     <= op_mag[0];
          div_b_reg     <= op_mag[1];
        end else begin
          mul_start_reg <= 1'b1;
          mul_a_reg     <= op_mag[0];
          mul_b_reg     <= op_mag[1];
        end
      end
      if (state_reg == MUL_WAIT && mul_done && !kill) raw_reg <= mul_product;
      if (state_reg == DIV_WAIT && div_done && !kill) raw_reg <= {div_quotient, div_remainder};
      if (state_reg == SIGNFIX && !kill) begin
        result_reg      <= fix_result;
        cache_valid_reg <= 1'b1;
        cache_div_reg   <= is_div_reg;
        cache_sgn_reg   <= key_sgn_reg;
        cache_rs1_reg   <= key_rs1_reg;
        cache_rs2_reg   <= key_rs2_reg;
        cache_val_reg   <= fix_value;
      end
      if (kill && state_reg != IDLE) cache_valid_reg <= 1'b0;
    end
  end

  assign mul_start = mul_start_reg;
  assign div_start = div_start_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign div_a     = div_a_reg;
  assign div_b     = div_b_reg;
  assign result    = result_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE) && !kill;

endmodule

// File: tb/tb_rv32m_muldiv_sequencer.sv
// Bench for rv32m_muldiv_sequencer: directed scenarios plus randomized ops checked
// against a 64-bit arithmetic reference and a scoreboard model of the result cache.
module tb_rv32m_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        nRST, start, mul, div, rem, usign_usign, sign_sign, sign_usign, lower_word, kill;
  logic [31:0] rs1_data, rs2_data;
  logic        mul_start, mul_done, div_start, div_done, busy, done;
  logic [31:0] mul_a, mul_b, div_a, div_b, div_quotient, div_remainder, result;
  logic [63:0] mul_product;

  rv32m_muldiv_sequencer dut (
    .CLK(CLK), .nRST(nRST), .start(start), .mul(mul), .div(div), .rem(rem),
    .usign_usign(usign_usign), .sign_sign(sign_sign), .sign_usign(sign_usign),
    .lower_word(lower_word), .kill(kill), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_product(mul_product), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  int mul_lat = 3, div_lat = 4;
  int mul_cnt = 0, div_cnt = 0;
  int mul_starts = 0, div_starts = 0, mul_dones = 0, div_dones = 0;
  logic [31:0] ua, ub, da, db;

  // Reference cache scoreboard
  bit          rc_valid = 0;
  bit          rc_div;
  int          rc_sgn;
  logic [31:0] rc_a, rc_b;

  // External unit models, operating on the falling edge to stay clear of the DUT edge.
  initial forever begin
    @(negedge CLK);
    mul_done = 1'b0;
    div_done = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        mul_done    = 1'b1;
        mul_product = {32'd0, ua} * {32'd0, ub};
        mul_dones++;
      end
    end
    if (mul_start === 1'b1) begin ua = mul_a; ub = mul_b; mul_cnt = mul_lat; mul_starts++; end
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_done      = 1'b1;
        div_quotient  = (db == 0) ? 32'hFFFF_FFFF : da / db;
        div_remainder = (db == 0) ? da : da % db;
        div_dones++;
      end
    end
    if (div_start === 1'b1) begin da = div_a; db = div_b; div_cnt = div_lat; div_starts++; end
  end

  function automatic logic [31:0] ref_res(bit is_div, bit isrem, bit lower, int sgn,
                                          logic [31:0] a, logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = {{32{(sgn != 0) & a[31]}}, a};
    sb = {{32{(sgn == 2) & b[31]}}, b};
    if (!is_div) begin
      p = sa * sb;
      return lower ? p[31:0] : p[63:32];
    end
    if (b == 0) return isrem ? a : 32'hFFFF_FFFF;
    if (sgn == 2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isrem ? 32'd0 : 32'h8000_0000;
    q = sa / sb;
    r = sa % sb;
    return isrem ? r[31:0] : q[31:0];
  endfunction

  function automatic bit ref_bypass(bit is_div, int sgn, logic [31:0] a, logic [31:0] b);
    return is_div && (b == 0 || (sgn == 2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic bit ref_hit(bit is_div, int sgn, logic [31:0] a, logic [31:0] b);
    return rc_valid && rc_div == is_div && rc_sgn == sgn && rc_a == a && rc_b == b;
  endfunction

  function automatic logic [31:0] mag(logic [31:0] v, bit s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  task automatic ref_note(bit is_div, int sgn, logic [31:0] a, logic [31:0] b);
    if (!ref_bypass(is_div, sgn, a, b) && !ref_hit(is_div, sgn, a, b)) begin
      rc_valid = 1; rc_div = is_div; rc_sgn = sgn; rc_a = a; rc_b = b;
    end
  endtask

  task automatic set_op(bit is_div, bit isrem, bit lower, int sgn, logic [31:0] a, logic [31:0] b);
    mul = !is_div; div = is_div; rem = isrem; lower_word = lower;
    sign_sign = (sgn == 2); sign_usign = (sgn == 1); usign_usign = (sgn == 0);
    rs1_data = a; rs2_data = b;
  endtask

  // Issues one op and waits (bounded) for done; reports result, latency and unit starts.
  task automatic run_op(input bit is_div, input bit isrem, input bit lower, input int sgn,
                        input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                        output int cycles, output int starts, output bit held, output bit single);
    logic [31:0] prev;
    int m0, d0;
    prev = result; m0 = mul_starts; d0 = div_starts; held = 1;
    set_op(is_div, isrem, lower, sgn, a, b);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 300) begin
      if (result !== prev) held = 0;
      @(posedge CLK); #1;
      cycles++;
    end
    res = result;
    @(posedge CLK); #1;
    single = (done === 1'b0) && (busy === 1'b0);
    starts = (mul_starts - m0) + (div_starts - d0);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if ({mul_start, div_start} !== 2'b00) begin bad++; $display("FAIL reset_starts got=%b want=00", {mul_start, div_start}); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if ({mul_a, mul_b, div_a, div_b} !== 128'd0) begin bad++; $display("FAIL reset_operands got=%h want=0", {mul_a, mul_b, div_a, div_b}); end
    nRST = 1'b1;
    @(posedge CLK); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    rc_valid = 0;
  endtask

  task automatic test_mulh_cache();
    logic [31:0] res; int cyc, st; bit held, single;
    mul_lat = 3;
    run_op(0, 0, 0, 2, 32'hFFFF_FFFE, 32'd3, res, cyc, st, held, single);
    ref_note(0, 2, 32'hFFFF_FFFE, 32'd3);
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_result got=%h want=ffffffff", res); end
    total++; if (mul_a !== 32'd2 || mul_b !== 32'd3) begin bad++; $display("FAIL mulh_operands got=%h/%h want=2/3", mul_a, mul_b); end
    total++; if (cyc != 6 || st != 1 || !single) begin bad++; $display("FAIL mulh_timing got cyc=%0d starts=%0d want cyc=6 starts=1", cyc, st); end
    run_op(0, 0, 1, 2, 32'hFFFF_FFFE, 32'd3, res, cyc, st, held, single);
    ref_note(0, 2, 32'hFFFF_FFFE, 32'd3);
    total++; if (res !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mul_hit_result got=%h want=fffffffa", res); end
    total++; if (cyc != 1 || st != 0) begin bad++; $display("FAIL mul_hit_timing got cyc=%0d starts=%0d want cyc=1 starts=0", cyc, st); end
  endtask

  task automatic test_div_cache();
    logic [31:0] res; int cyc, st; bit held, single;
    div_lat = 4;
    run_op(1, 0, 0, 2, 32'hFFFF_FFF9, 32'd2, res, cyc, st, held, single);
    ref_note(1, 2, 32'hFFFF_FFF9, 32'd2);
    total++; if (div_a !== 32'd7 || div_b !== 32'd2) begin bad++; $display("FAIL div_operands got=%h/%h want=7/2", div_a, div_b); end
    total++; if (res !== 32'hFFFF_FFFD || cyc != 7 || st != 1) begin bad++; $display("FAIL div_result got=%h cyc=%0d starts=%0d want=fffffffd cyc=7 starts=1", res, cyc, st); end
    run_op(1, 1, 0, 2, 32'hFFFF_FFF9, 32'd2, res, cyc, st, held, single);
    ref_note(1, 2, 32'hFFFF_FFF9, 32'd2);
    total++; if (res !== 32'hFFFF_FFFF || cyc != 1 || st != 0) begin bad++; $display("FAIL rem_hit got=%h cyc=%0d starts=%0d want=ffffffff cyc=1 starts=0", res, cyc, st); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res; int cyc, st; bit held, single;
    run_op(1, 0, 0, 0, 32'h1234, 32'd0, res, cyc, st, held, single);
    total++; if (res !== 32'hFFFF_FFFF || cyc != 1 || st != 0) begin bad++; $display("FAIL divu_zero got=%h cyc=%0d starts=%0d want=ffffffff cyc=1 starts=0", res, cyc, st); end
    run_op(1, 1, 0, 0, 32'h1234, 32'd0, res, cyc, st, held, single);
    total++; if (res !== 32'h1234 || cyc != 1 || st != 0) begin bad++; $display("FAIL remu_zero got=%h cyc=%0d starts=%0d want=1234 cyc=1 starts=0", res, cyc, st); end
  endtask

  task automatic test_overflow();
    logic [31:0] res; int cyc, st; bit held, single;
    run_op(1, 0, 0, 2, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, st, held, single);
    total++; if (res !== 32'h8000_0000 || st != 0) begin bad++; $display("FAIL div_ovf got=%h starts=%0d want=80000000 starts=0", res, st); end
    run_op(1, 1, 0, 2, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, st, held, single);
    total++; if (res !== 32'd0 || st != 0) begin bad++; $display("FAIL rem_ovf got=%h starts=%0d want=0 starts=0", res, st); end
  endtask

  task automatic test_kill();
    logic [31:0] res; int cyc, st, d0, dones; bit held, single;
    mul_lat = 6;
    run_op(0, 0, 1, 0, 32'd5, 32'd7, res, cyc, st, held, single);
    ref_note(0, 0, 32'd5, 32'd7);
    total++; if (res !== 32'd35) begin bad++; $display("FAIL kill_prep got=%h want=23", res); end
    set_op(0, 0, 1, 0, 32'd9, 32'd11);
    start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1; kill = 1'b1;
    @(posedge CLK); #1; kill = 1'b0;
    d0 = mul_dones; dones = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      if (done === 1'b1) dones++;
      @(posedge CLK); #1;
      cyc++;
    end
    rc_valid = 0;
    total++; if (mul_dones - d0 != 1 || cyc == 0 || cyc >= 50 || dones != 0 || done !== 1'b0)
      begin bad++; $display("FAIL kill_drain got unit_dones=%0d busy_cycles=%0d done_pulses=%0d want 1/1..49/0", mul_dones - d0, cyc, dones); end
    run_op(0, 0, 1, 0, 32'd5, 32'd7, res, cyc, st, held, single);
    ref_note(0, 0, 32'd5, 32'd7);
    total++; if (res !== 32'd35 || st != 1 || cyc != 9) begin bad++; $display("FAIL kill_cache_miss got=%h starts=%0d cyc=%0d want=23 starts=1 cyc=9", res, st, cyc); end
  endtask

  task automatic test_busy_reset();
    int m0, d0, dones, busies;
    div_lat = 8;
    set_op(1, 0, 0, 2, 32'd100, 32'd7);
    start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    m0 = mul_starts;
    set_op(0, 0, 1, 0, 32'd3, 32'd4);
    start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    total++; if (busy !== 1'b1 || mul_starts != m0) begin bad++; $display("FAIL start_while_busy got busy=%b mul_starts=%0d want busy=1 mul_starts=0", busy, mul_starts - m0); end
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    rc_valid = 0;
    total++; if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_op_reset got busy=%b result=%h done=%b want 0/0/0", busy, result, done); end
    d0 = div_dones; dones = 0; busies = 0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
    end
    total++; if (div_dones - d0 != 1 || dones != 0 || busies != 0) begin bad++; $display("FAIL late_div_done got unit_dones=%0d done_pulses=%0d busy_cycles=%0d want 1/0/0", div_dones - d0, dones, busies); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_res;
    bit is_div, isrem, lower, bp, hit, held, single, have_prev;
    int sgn, cyc, st, exp_cyc, exp_st;
    have_prev = 0; is_div = 0; sgn = 0; a = 0; b = 0;
    for (int n = 0; n < 40; n++) begin
      if (!(have_prev && $urandom_range(0, 2) == 0)) begin
        is_div = $urandom_range(0, 1);
        sgn = $urandom_range(0, 2);
        a = pick();
        b = pick();
      end
      have_prev = 1;
      isrem = is_div ? $urandom_range(0, 1) : 1'b0;
      lower = is_div ? 1'b0 : $urandom_range(0, 1);
      mul_lat = $urandom_range(1, 5);
      div_lat = $urandom_range(1, 5);
      exp_res = ref_res(is_div, isrem, lower, sgn, a, b);
      bp = ref_bypass(is_div, sgn, a, b);
      hit = !bp && ref_hit(is_div, sgn, a, b);
      exp_cyc = (bp || hit) ? 1 : (is_div ? div_lat : mul_lat) + 3;
      exp_st = (bp || hit) ? 0 : 1;
      run_op(is_div, isrem, lower, sgn, a, b, res, cyc, st, held, single);
      ref_note(is_div, sgn, a, b);
      total++; if (res !== exp_res) begin bad++; $display("FAIL rand_result n=%0d div=%0d rem=%0d lo=%0d sgn=%0d a=%h b=%h got=%h want=%h", n, is_div, isrem, lower, sgn, a, b, res, exp_res); end
      total++; if (cyc != exp_cyc) begin bad++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, cyc, exp_cyc); end
      total++; if (st != exp_st) begin bad++; $display("FAIL rand_unit_starts n=%0d got=%0d want=%0d", n, st, exp_st); end
      total++; if (!held || !single) begin bad++; $display("FAIL rand_result_hold n=%0d got held=%0d single=%0d want 1/1", n, held, single); end
      if (exp_st == 1) begin
        total++;
        if (is_div ? (div_a !== mag(a, sgn != 0) || div_b !== mag(b, sgn == 2))
                   : (mul_a !== mag(a, sgn != 0) || mul_b !== mag(b, sgn == 2))) begin
          bad++;
          $display("FAIL rand_magnitudes n=%0d got=%h/%h want=%h/%h", n, is_div ? div_a : mul_a,
                   is_div ? div_b : mul_b, mag(a, sgn != 0), mag(b, sgn == 2));
        end
      end
    end
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; kill = 1'b0;
    set_op(0, 0, 0, 0, 32'd0, 32'd0);
    mul_done = 1'b0; div_done = 1'b0;
    mul_product = 64'd0; div_quotient = 32'd0; div_remainder = 32'd0;
    test_reset();
    test_mulh_cache();
    test_div_cache();
    test_div_zero();
    test_overflow();
    test_kill();
    test_random();
    test_busy_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
